// File: rtl/rule110_row_serializer.sv
// Row-to-word serializer for the rule-110 generator.
// Buffers one generation row and emits it as NWORDS words, most significant
// word first, with valid/ready handshakes on both the row and word sides.
//
//   state | meaning
//   ------+------------------------------------------------
//   IDLE  | no row buffered, row_ready high
//   SEND  | row buffered, words pending on word_out
module rule110_row_serializer #(
  parameter  int ROW_W  = 256,
  parameter  int WORD_W = 16,
  localparam int NWORDS = ROW_W / WORD_W,
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              row_valid,
  output logic              row_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_last,
  output logic [15:0]       gen_count
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t             state_q;
  logic [ROW_W-1:0]   buf_q;
  logic [IDX_W-1:0]   idx_q;
  logic [15:0]        gen_count_q;
  logic [WORD_W-1:0]  word_out_d;

  logic at_last;
  logic word_hs;
  logic row_hs;

  // Handshake qualifiers; row_ready reaches back combinationally through
  // word_ready so a new row can be taken on the last word with no bubble.
  always_comb begin
    at_last   = (idx_q == LAST_IDX);
    word_hs   = (state_q == SEND) && word_ready;
    row_ready = !rst && ((state_q == IDLE) || (word_hs && at_last));
    row_hs    = row_valid && row_ready;
  end

  // Select the current word, word 0 being the leftmost cells of the row.
  always_comb begin
    word_out_d = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        word_out_d = buf_q[ROW_W-1-WORD_W*i -: WORD_W];
      end
    end
  end

  // Serializer FSM: row capture, word stepping and completed-row counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      idx_q       <= '0;
      gen_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (row_hs) begin
            buf_q   <= row_in;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (word_hs) begin
            if (at_last) begin
              gen_count_q <= gen_count_q + 16'd1;
              idx_q       <= '0;
              if (row_hs) begin
                buf_q   <= row_in;
                state_q <= SEND;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign word_out   = word_out_d;
  assign word_valid = (state_q == SEND);
  assign word_idx   = idx_q;
  assign word_last  = (state_q == SEND) && at_last;
  assign gen_count  = gen_count_q;

endmodule

// File: tb/tb_rule110_row_serializer.sv
// Scoreboard bench for rule110_row_serializer at default parameters.
module tb_rule110_row_serializer;

  logic         clk;
  logic         rst;
  logic [255:0] row_in;
  logic         row_valid;
  logic         row_ready;
  logic [15:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic [3:0]   word_idx;
  logic         word_last;
  logic [15:0]  gen_count;

  rule110_row_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_idx   (word_idx),
    .word_last  (word_last),
    .gen_count  (gen_count)
  );

  typedef struct {
    logic [15:0] w;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int first_hs = -1;
  int last_hs  = -1;

  localparam logic [255:0] ROW_A = 256'h0123_4567_89AB_CDEF_1357_9BDF_2468_ACE0_0F0F_F0F0_3C3C_C3C3_5A5A_A5A5_7E81_FEDC;
  localparam logic [255:0] ROW_B = 256'hB000_B001_B002_B003_B004_B005_B006_B007_B008_B009_B00A_B00B_B00C_B00D_B00E_B00F;
  localparam logic [255:0] ROW_C = {16{16'hDEAD}};

  logic [15:0] a_words [16] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF,
                                16'h1357, 16'h9BDF, 16'h2468, 16'hACE0,
                                16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3,
                                16'h5A5A, 16'hA5A5, 16'h7E81, 16'hFEDC};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_a();
    for (int i = 0; i < 16; i++) exp_q.push_back('{a_words[i], 4'(i), (i == 15)});
  endtask

  task automatic push_b();
    for (int i = 0; i < 16; i++) exp_q.push_back('{16'hB000 + 16'(i), 4'(i), (i == 15)});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Monitor: pop on every word handshake, and check stalled words hold.
  logic        stall_seen = 1'b0;
  logic [15:0] held_w;
  logic [3:0]  held_idx;
  logic        held_last;

  always @(negedge clk) begin
    if (!rst && word_valid) begin
      if (stall_seen) begin
        chk("stall_word", 32'(word_out), 32'(held_w));
        chk("stall_idx", 32'(word_idx), 32'(held_idx));
        chk("stall_last", 32'(word_last), 32'(held_last));
      end
      if (word_ready) begin
        stall_seen = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_out", 32'(word_out), 32'(e.w));
          chk("word_idx", 32'(word_idx), 32'(e.idx));
          chk("word_last", 32'(word_last), 32'(e.last));
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end else begin
        stall_seen = 1'b1;
        held_w     = word_out;
        held_idx   = word_idx;
        held_last  = word_last;
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    row_in     = '0;
    row_valid  = 1'b0;
    word_ready = 1'b0;

    // Reset state, mid-reset between edges.
    #3;
    chk("rst_row_ready", 32'(row_ready), 32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_idx", 32'(word_idx), 32'd0);
    chk("rst_word_last", 32'(word_last), 32'd0);
    chk("rst_gen_count", 32'(gen_count), 32'd0);
    repeat (2) @(posedge clk);

    // Single row, full-rate consumer, taken on the first edge after reset.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_row_ready", 32'(row_ready), 32'd1);
    row_in = ROW_A; row_valid = 1'b1; word_ready = 1'b1;
    push_a();
    first_hs = -1;
    @(posedge clk); #1;
    row_valid = 1'b0;
    chk("first_word_latency", 32'(word_valid), 32'd1);
    wait_drain();
    chk("t1_span", 32'(last_hs - first_hs), 32'd15);
    chk("t1_gen_count", 32'(gen_count), 32'd1);
    chk("t1_idle_valid", 32'(word_valid), 32'd0);
    chk("t1_idle_ready", 32'(row_ready), 32'd1);

    // Same row, consumer toggling ready every cycle.
    row_in = ROW_A; row_valid = 1'b1; word_ready = 1'b1;
    push_a();
    first_hs = -1;
    @(posedge clk); #1;
    row_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) word_ready = ~word_ready;
      n++;
    end
    chk("t2_drained", 32'(exp_q.size()), 32'd0);
    word_ready = 1'b1;
    chk("t2_span", 32'(last_hs - first_hs), 32'd30);
    chk("t2_gen_count", 32'(gen_count), 32'd2);

    // Back-to-back rows: B taken on A's last-word handshake.
    row_in = ROW_A; row_valid = 1'b1;
    push_a();
    push_b();
    first_hs = -1;
    @(posedge clk); #1;
    row_in = ROW_B;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!row_ready && n < 40);
    chk("t3_ready_cycle", 32'(n), 32'd16);
    @(posedge clk); #1;
    row_valid = 1'b0;
    wait_drain();
    chk("t3_span", 32'(last_hs - first_hs), 32'd31);
    chk("t3_gen_count", 32'(gen_count), 32'd4);

    // Different row offered mid-send must be ignored.
    row_in = ROW_A; row_valid = 1'b1;
    push_a();
    @(posedge clk); #1;
    row_in = ROW_C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_ready_low", 32'(row_ready), 32'd0);
    @(posedge clk); #1;
    row_valid = 1'b0;
    wait_drain();
    chk("t4_gen_count", 32'(gen_count), 32'd5);
    chk("t4_no_capture", 32'(word_valid), 32'd0);

    // Asynchronous reset after word 7 handshake.
    row_in = ROW_A; row_valid = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back('{a_words[i], 4'(i), 1'b0});
    @(posedge clk); #1;
    row_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_word_valid", 32'(word_valid), 32'd0);
    chk("arst_word_idx", 32'(word_idx), 32'd0);
    chk("arst_word_last", 32'(word_last), 32'd0);
    chk("arst_gen_count", 32'(gen_count), 32'd0);
    chk("arst_row_ready", 32'(row_ready), 32'd0);
    chk("arst_words_seen", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    row_in = ROW_B; row_valid = 1'b1;
    push_b();
    @(posedge clk); #1;
    row_valid = 1'b0;
    chk("arst_restart_idx", 32'(word_idx), 32'd0);
    wait_drain();
    chk("arst_gen_count_after", 32'(gen_count), 32'd1);

    // gen_count wrap from 0xFFFF.
    force dut.gen_count_q = 16'hFFFF;
    #1;
    release dut.gen_count_q;
    chk("wrap_preload", 32'(gen_count), 32'hFFFF);
    row_in = ROW_A; row_valid = 1'b1;
    push_a();
    @(posedge clk); #1;
    row_valid = 1'b0;
    wait_drain();
    chk("wrap_gen_count", 32'(gen_count), 32'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rule110_row_serializer.md
RULE110_ROW_SERIALIZER -- requirements
Module: rule110_row_serializer

Interface
REQ-001 SHALL have parameter ROW_W, default 256: cells per generation row.
REQ-002 SHALL have parameter WORD_W, default 16: bits per output word; ROW_W SHALL be an integer multiple of WORD_W.
REQ-003 SHALL define NWORDS = ROW_W/WORD_W (default 16) and IDX_W = clog2(NWORDS) (default 4).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port row_in  input  ROW_W  generation row from the rule-110 step stage, bit ROW_W-1 is the leftmost cell.
REQ-007 SHALL have port row_valid  input  1  row_in holds a valid generation.
REQ-008 SHALL have port row_ready  output  1  serializer accepts row_in this cycle.
REQ-009 SHALL have port word_out  output  WORD_W  current output word.
REQ-010 SHALL have port word_valid  output  1  word_out valid.
REQ-011 SHALL have port word_ready  input  1  consumer accepts word_out this cycle.
REQ-012 SHALL have port word_idx  output  IDX_W  index of word_out within its row, 0 = most significant word.
REQ-013 SHALL have port word_last  output  1  high with word_valid when word_idx = NWORDS-1.
REQ-014 SHALL have port gen_count  output  16  number of rows fully emitted since reset.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no row buffered) and SEND (row buffered, words pending).
REQ-016 Row handshake SHALL occur on a rising edge where row_valid and row_ready are both high; row_in SHALL then be captured into an internal ROW_W-bit buffer, word_idx set to 0, state set to SEND.
REQ-017 row_ready SHALL be high in IDLE, and in SEND only in a cycle where word_valid, word_ready are high and word_idx = NWORDS-1 (back-to-back rows, combinational path from word_ready permitted); otherwise low.
REQ-018 row_in presented while row_ready is low SHALL be ignored and not captured.
REQ-019 word_valid SHALL be high exactly when state is SEND.
REQ-020 word_out SHALL equal buffer[ROW_W-1-WORD_W*word_idx -: WORD_W]; word 0 = buffer[255:240], word 15 = buffer[15:0] at defaults.
REQ-021 Word handshake SHALL occur on a rising edge where word_valid and word_ready are both high; word_idx SHALL then increment by 1.
REQ-022 While word_valid is high and word_ready low, word_out, word_idx and word_last SHALL hold stable.
REQ-023 On the handshake of the word with word_idx = NWORDS-1: gen_count SHALL increment by 1 (wrapping 0xFFFF -> 0x0000); word_idx SHALL return to 0; state SHALL go to SEND with the new buffer if a row handshake occurs in the same cycle, else to IDLE.
REQ-024 Latency: first word SHALL be valid the cycle after the row handshake; with word_ready held high a row SHALL complete in exactly NWORDS cycles and back-to-back rows SHALL stream with no bubble.
REQ-025 In IDLE, word_out SHALL be driven from the stale buffer and word_idx SHALL be 0; consumers SHALL qualify with word_valid.

Reset
REQ-026 While rst is high, state SHALL be IDLE, buffer 0, word_idx 0, gen_count 0, word_valid 0, word_last 0, and row_ready SHALL be forced low.
REQ-027 rst assertion SHALL take effect immediately without a clock edge; a partially emitted row SHALL be discarded and not counted.
REQ-028 After rst deasserts, row_ready SHALL be high from the first cycle and the first row handshake SHALL be honoured on the first rising edge.

Verification
REQ-029 Reset, then row_in = 256'h0123_4567_89AB_CDEF_..._FEDC (16 distinct words), row_valid 1 one cycle, word_ready 1 -> words 0x0123, 0x4567, ... in order on 16 consecutive cycles, word_last only on 16th, gen_count 1 afterwards.
REQ-030 Same row with word_ready toggled 1/0 each cycle -> 16 words emitted over 31 cycles, each word stable while stalled, no word duplicated or skipped.
REQ-031 Two rows offered continuously with word_ready 1 -> row B captured on row A's last-word handshake, 32 consecutive valid words, gen_count 2.
REQ-032 row_valid asserted with a different row during SEND before the last word -> not captured; emitted words match the first row only.
REQ-033 Assert rst asynchronously after word 7 handshake -> word_valid, word_idx, gen_count read 0 before next edge; next row starts at word 0.
REQ-034 Preload 65535 completed rows (or force gen_count = 0xFFFF) then complete one row -> gen_count = 0x0000.
